// File: rtl/rs_sync_fifo_prog.sv
// rs_sync_fifo_prog: single-clock FIFO with programmable almost-full and
// almost-empty thresholds, sticky overflow/underflow flags, synchronous
// flush, and a choice between registered read and first-word-fall-through.
module rs_sync_fifo_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc, rd_acc;

    // Status flags are decoded from the registered count only.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // FWFT shows the head word combinationally; otherwise the read register.
    assign dout = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;

    // Next-state: accepts, pointer/count update, sticky errors, read register.
    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (flush) begin
            // Flush drops both requests; registered dout is left alone.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // A set in the same cycle as clr_err wins over the clear.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_en && full)  ovf_d = 1'b1;
        if (rd_en && empty) udf_d = 1'b1;
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: tb/tb_rs_sync_fifo_prog.sv
// Bench for rs_sync_fifo_prog: a registered-read and an FWFT instance share
// stimulus; a queue model predicts occupancy/flags and a scoreboard checks
// read data.
module tb_rs_sync_fifo_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] din = '0;

    logic [15:0] dout0, dout1;
    logic        full0, af0, empty0, ae0, ovf0, udf0;
    logic        full1, af1, empty1, ae1, ovf1, udf1;
    logic [4:0]  count0, count1;

    always #5 clk = ~clk;

    rs_sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(16), .FWFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout0),
        .full(full0), .almost_full(af0), .empty(empty0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0));

    rs_sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(16), .FWFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout1),
        .full(full1), .almost_full(af1), .empty(empty1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] mq[$];     // FIFO contents
    logic [15:0] sb[$];     // words expected on registered dout
    logic [15:0] last_dout = '0;
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    logic [15:0] dctr = 16'h0100;

    typedef struct {
        int   rep;
        logic wr, rd, fl, clr;
        int   exp_cnt;
        logic exp_ovf, exp_udf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz = mq.size();
        chk("count", 32'(count0), 32'(sz));
        chk("full", 32'(full0), 32'(sz == 16));
        chk("empty", 32'(empty0), 32'(sz == 0));
        chk("almost_full", 32'(af0), 32'(sz >= 14));
        chk("almost_empty", 32'(ae0), 32'(sz <= 2));
        chk("overflow", 32'(ovf0), 32'(m_ovf));
        chk("underflow", 32'(udf0), 32'(m_udf));
        if (sb.size() > 0) last_dout = sb.pop_front();
        chk("dout_reg", 32'(dout0), 32'(last_dout));
        chk("fwft_flags", {count1, full1, af1, empty1, ae1, ovf1, udf1},
                          {count0, full0, af0, empty0, ae0, ovf0, udf0});
        if (sz > 0) chk("dout_fwft", 32'(dout1), 32'(mq[0]));
    endtask

    // Drive one cycle, advance the model, then check after the edge.
    task automatic step(input logic w, input logic r, input logic f,
                        input logic c, input logic [15:0] d);
        int sz = mq.size();
        wr_en = w; rd_en = r; flush = f; clr_err = c; din = d;
        if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
        if (w && sz == 16) m_ovf = 1'b1;
        if (r && sz == 0)  m_udf = 1'b1;
        if (f) mq.delete();
        else begin
            if (r && sz > 0)  sb.push_back(mq.pop_front());
            if (w && sz < 16) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_state();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(count0), 0);
        chk({tag, "_flags"}, {full0, af0, empty0, ae0, ovf0, udf0}, 32'b001100);
        chk({tag, "_dout"}, 32'(dout0), 0);
        chk({tag, "_fwft_flags"}, {full1, af1, empty1, ae1, ovf1, udf1}, 32'b001100);
    endtask

    vec_t vt[$];

    initial begin
        // Boundary sequence; starts empty with clear flags.
        vt = '{
            '{1,  1,1,0,0, 1,  0,1},   // rd+wr at 0 -> 1, underflow
            '{1,  0,0,0,1, 1,  0,0},
            '{15, 1,0,0,0, 16, 0,0},
            '{1,  1,0,0,0, 16, 1,0},   // write while full
            '{1,  1,1,0,0, 15, 1,0},   // rd+wr at 16 -> 15
            '{1,  1,0,0,1, 16, 0,0},
            '{9,  0,1,0,0, 7,  0,0},
            '{3,  1,1,0,0, 7,  0,0},   // rd+wr at 7 holds
            '{7,  0,1,0,0, 0,  0,0},
            '{1,  0,1,0,0, 0,  0,1},   // read while empty
            '{1,  0,1,0,1, 0,  0,1},   // set beats clear
            '{1,  0,0,0,1, 0,  0,0},
            '{5,  1,0,0,0, 5,  0,0},
            '{20, 1,1,0,0, 5,  0,0},   // pointers wrap repeatedly
            '{5,  0,1,0,0, 0,  0,0},
            '{1,  0,1,0,0, 0,  0,1},
            '{9,  1,0,0,0, 9,  0,1},
            '{1,  1,0,1,0, 0,  0,1},   // flush with wr_en, flags kept
            '{1,  0,0,0,1, 0,  0,0}
        };

        #1;
        chk_reset_vals("reset");
        #11 rst_n = 1'b1;

        // Fill/drain with registered read
        for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 16'(i));
        chk("fill_full", 32'(full0), 1);
        chk("fill_count", 32'(count0), 16);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0, '0);
            chk("drain_dout", 32'(dout0), 32'(i));
        end
        chk("drain_empty", 32'(empty0), 1);

        // Thresholds
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, dctr++);
        chk("af_at14", {af0, ae0}, 32'b10);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, '0);
        chk("cnt5_ae", {count0, ae0}, {5'd5, 1'b0});
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        chk("cnt2_ae", {count0, ae0}, {5'd2, 1'b1});
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, '0);

        // Table-driven boundary vectors
        foreach (vt[k]) begin
            for (int j = 0; j < vt[k].rep; j++)
                step(vt[k].wr, vt[k].rd, vt[k].fl, vt[k].clr, dctr++);
            chk($sformatf("vec%0d_count", k), 32'(count0), 32'(vt[k].exp_cnt));
            chk($sformatf("vec%0d_err", k), {ovf0, udf0}, {vt[k].exp_ovf, vt[k].exp_udf});
        end

        // FWFT: first word visible before any read, next word on read edge
        step(1, 0, 0, 0, 16'hABCD);
        chk("fwft_first", {empty1, dout1}, {1'b0, 16'hABCD});
        step(1, 0, 0, 0, 16'h1234);
        step(0, 1, 0, 0, '0);
        chk("fwft_next", 32'(dout1), 32'h1234);
        chk("reg_after_read", 32'(dout0), 32'hABCD);
        step(0, 1, 0, 0, '0);

        // Reset mid-burst
        for (int i = 0; i < 5; i++) step(1, i[0], 0, 0, dctr++);
        wr_en = 1'b1; din = 16'hDEAD;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        wr_en = 1'b0;
        mq.delete(); sb.delete();
        last_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1, 0, 0, 0, 16'h5A5A);
        step(0, 1, 0, 0, '0);
        chk("post_reset_data", 32'(dout0), 32'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
